// File: rtl/tree_infer_engine.sv
// -----------------------------------------------------------------------------
// tree_infer_engine
// Compute stage of the tree accelerator. For every sample it walks each tree of
// the forest through the on-chip tree memory and feature memory. It sums the
// leaf values (32-bit wrap) into one prediction per sample, writes the
// prediction out, and pulses done once the whole task has finished.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle task start; only accepted while idle
//   n_trees/n_features/n_samples
//                       task configuration, latched on an accepted start
//   tree_rd_en/addr     node read {tree,node}; tree_rd_data is valid one cycle later
//   feat_rd_en/addr     feature read base+fidx; feat_rd_data is valid one cycle later
//   pred_we/addr/data   prediction write, one per sample
//   busy                high in every state except idle
//   done                one-cycle end-of-task pulse
//   err                 sticky malformed-tree flag; cleared by the next accepted start
// -----------------------------------------------------------------------------
module tree_infer_engine #(
    parameter int MAX_SAMPLES = 10000,
    parameter int N_TREES     = 128,
    parameter int TREES_LEN   = 256,
    localparam int AW = $clog2(MAX_SAMPLES),
    localparam int TW = $clog2(N_TREES),
    localparam int NW = $clog2(TREES_LEN)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [31:0]    n_trees,
    input  logic [31:0]    n_features,
    input  logic [31:0]    n_samples,
    output logic           tree_rd_en,
    output logic [TW+NW-1:0] tree_rd_addr,
    input  logic [63:0]    tree_rd_data,
    output logic           feat_rd_en,
    output logic [AW-1:0]  feat_rd_addr,
    input  logic [31:0]    feat_rd_data,
    output logic           pred_we,
    output logic [AW-1:0]  pred_addr,
    output logic [31:0]    pred_data,
    output logic           busy,
    output logic           done,
    output logic           err
);

    typedef enum logic [2:0] {
        IDLE, NODE_RD, NODE_CHK, FEAT_CMP, WRITE, DONE
    } state_t;

    state_t          state_reg;
    logic [31:0]     n_trees_reg;
    logic [31:0]     n_feat_reg;
    logic [31:0]     n_samp_reg;
    logic [31:0]     sample_reg;
    logic [31:0]     tree_reg;
    logic [31:0]     base_reg;
    logic [31:0]     steps_reg;
    logic [31:0]     acc_reg;
    logic [31:0]     thr_reg;
    logic [NW-1:0]   left_reg;
    logic [NW-1:0]   right_reg;

    // Decode of the node word; only meaningful in NODE_CHK.
    logic            node_leaf;
    logic [7:0]      node_fidx;
    logic            force_leaf;
    logic [31:0]     leaf_val;
    logic [31:0]     acc_next;
    logic [31:0]     tree_inc;
    logic            last_tree;
    logic [31:0]     feat_sum;
    logic [NW-1:0]   child_next;

    assign node_leaf  = tree_rd_data[63];
    assign node_fidx  = tree_rd_data[39:32];
    // A node that exhausted its step budget or names a missing feature is
    // treated as a leaf worth 0 so the walk always terminates.
    assign force_leaf = !node_leaf &&
                        ((steps_reg == TREES_LEN) || ({24'd0, node_fidx} >= n_feat_reg));
    assign leaf_val   = node_leaf ? tree_rd_data[31:0] : 32'd0;
    assign acc_next   = acc_reg + leaf_val;
    assign tree_inc   = tree_reg + 32'd1;
    assign last_tree  = (tree_reg == n_trees_reg - 32'd1);
    assign feat_sum   = base_reg + {24'd0, node_fidx};
    assign child_next = ($signed(feat_rd_data) <= $signed(thr_reg)) ? left_reg : right_reg;

    // The feature read depends on the node word that only arrives during
    // NODE_CHK, so it has to be decoded in that same cycle.
    assign feat_rd_en   = (state_reg == NODE_CHK) && !node_leaf && !force_leaf;
    assign feat_rd_addr = feat_rd_en ? feat_sum[AW-1:0] : '0;

    wire unused_bits = &{1'b0, tree_rd_data[62:56], feat_sum[31:AW]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            n_trees_reg  <= '0;
            n_feat_reg   <= '0;
            n_samp_reg   <= '0;
            sample_reg   <= '0;
            tree_reg     <= '0;
            base_reg     <= '0;
            steps_reg    <= '0;
            acc_reg      <= '0;
            thr_reg      <= '0;
            left_reg     <= '0;
            right_reg    <= '0;
            tree_rd_en   <= 1'b0;
            tree_rd_addr <= '0;
            pred_we      <= 1'b0;
            pred_addr    <= '0;
            pred_data    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            // Strobes are raised on entry to the state that owns them.
            tree_rd_en <= 1'b0;
            pred_we    <= 1'b0;
            done       <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        n_trees_reg  <= n_trees;
                        n_feat_reg   <= n_features;
                        n_samp_reg   <= n_samples;
                        err          <= 1'b0;
                        acc_reg      <= '0;
                        sample_reg   <= '0;
                        tree_reg     <= '0;
                        base_reg     <= '0;
                        steps_reg    <= '0;
                        busy         <= 1'b1;
                        if (n_samples == 32'd0) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg    <= NODE_RD;
                            tree_rd_en   <= 1'b1;
                            tree_rd_addr <= '0;
                        end
                    end
                end
                NODE_RD: begin
                    steps_reg <= steps_reg + 32'd1;
                    state_reg <= NODE_CHK;
                end
                NODE_CHK: begin
                    if (node_leaf || force_leaf) begin
                        acc_reg <= acc_next;
                        if (force_leaf)
                            err <= 1'b1;
                        if (last_tree) begin
                            state_reg <= WRITE;
                            pred_we   <= 1'b1;
                            pred_addr <= sample_reg[AW-1:0];
                            pred_data <= acc_next;
                        end else begin
                            tree_reg     <= tree_inc;
                            steps_reg    <= '0;
                            state_reg    <= NODE_RD;
                            tree_rd_en   <= 1'b1;
                            tree_rd_addr <= {tree_inc[TW-1:0], {NW{1'b0}}};
                        end
                    end else begin
                        thr_reg   <= tree_rd_data[31:0];
                        left_reg  <= tree_rd_data[40 +: NW];
                        right_reg <= tree_rd_data[48 +: NW];
                        state_reg <= FEAT_CMP;
                    end
                end
                FEAT_CMP: begin
                    state_reg    <= NODE_RD;
                    tree_rd_en   <= 1'b1;
                    tree_rd_addr <= {tree_reg[TW-1:0], child_next};
                end
                WRITE: begin
                    acc_reg <= '0;
                    if (sample_reg == n_samp_reg - 32'd1) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                    end else begin
                        sample_reg   <= sample_reg + 32'd1;
                        base_reg     <= base_reg + n_feat_reg;
                        tree_reg     <= '0;
                        steps_reg    <= '0;
                        state_reg    <= NODE_RD;
                        tree_rd_en   <= 1'b1;
                        tree_rd_addr <= '0;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tree_infer_engine.sv
module tb_tree_infer_engine;

    localparam int MS = 64;
    localparam int NT = 8;
    localparam int TL = 4;
    localparam int AW = $clog2(MS);
    localparam int TAW = $clog2(NT) + $clog2(TL);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [31:0]     n_trees = '0, n_features = '0, n_samples = '0;
    logic            tree_rd_en;
    logic [TAW-1:0]  tree_rd_addr;
    logic [63:0]     tree_rd_data = '0;
    logic            feat_rd_en;
    logic [AW-1:0]   feat_rd_addr;
    logic [31:0]     feat_rd_data = '0;
    logic            pred_we;
    logic [AW-1:0]   pred_addr;
    logic [31:0]     pred_data;
    logic            busy, done, err;

    tree_infer_engine #(.MAX_SAMPLES(MS), .N_TREES(NT), .TREES_LEN(TL)) dut (
        .clk(clk), .rst(rst), .start(start),
        .n_trees(n_trees), .n_features(n_features), .n_samples(n_samples),
        .tree_rd_en(tree_rd_en), .tree_rd_addr(tree_rd_addr), .tree_rd_data(tree_rd_data),
        .feat_rd_en(feat_rd_en), .feat_rd_addr(feat_rd_addr), .feat_rd_data(feat_rd_data),
        .pred_we(pred_we), .pred_addr(pred_addr), .pred_data(pred_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [63:0] tree_mem [0:NT*TL-1];
    logic [31:0] feat_mem [0:MS-1];
    logic [31:0] pred_mem [0:MS-1];

    always @(posedge clk) begin
        if (tree_rd_en) tree_rd_data <= tree_mem[tree_rd_addr];
        if (feat_rd_en) feat_rd_data <= feat_mem[feat_rd_addr];
        if (pred_we)    pred_mem[pred_addr] <= pred_data;
    end

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic exp_err;

    typedef struct { logic [AW-1:0] a; logic [31:0] d; } exp_t;
    exp_t exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] nd(input bit leaf, input int l, input int r,
                                       input int f, input int v);
        return {leaf, 7'd0, r[7:0], l[7:0], f[7:0], v[31:0]};
    endfunction

    // Reference forest walk: for each sample, walk each tree from node 0 for at
    // most TL reads; sum leaves; bad nodes flag an error and contribute 0.
    function automatic void model(input int ns, input int nt, input int nf);
        exp_err = 1'b0;
        for (int s = 0; s < ns; s++) begin
            logic [31:0] acc;
            acc = '0;
            for (int t = 0; t < nt; t++) begin
                int node;
                node = 0;
                for (int st = 1; st <= TL; st++) begin
                    logic [63:0] w;
                    int fi;
                    w = tree_mem[t*TL + node];
                    fi = int'(w[39:32]);
                    if (w[63]) begin
                        acc = acc + w[31:0];
                        break;
                    end
                    if (st == TL || fi >= nf) begin
                        exp_err = 1'b1;
                        break;
                    end
                    if ($signed(feat_mem[s*nf + fi]) <= $signed(w[31:0]))
                        node = int'(w[47:40]) % TL;
                    else
                        node = int'(w[55:48]) % TL;
                end
            end
            exp_q.push_back('{a: AW'(s), d: acc});
        end
    endfunction

    // Single compare process: every prediction write against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (pred_we) begin
                $display("write addr=%0d data=%0d", pred_addr, $signed(pred_data));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual addr=%0d required none", pred_addr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pred_addr", 64'(pred_addr), 64'(e.a));
                    chk("pred_data", 64'(pred_data), 64'(e.d));
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_outs"}, {tree_rd_en, 64'(tree_rd_addr), feat_rd_en, 64'(feat_rd_addr),
                             pred_we, 64'(pred_addr), 64'(pred_data), busy, done, err} != 0, 64'd0);
    endtask

    task automatic run_task(input string name, input int ns, input int nt, input int nf,
                            input int inject, output int write_k, output int done_k);
        model(ns, nt, nf);
        done_cnt = 0;
        write_k = -1;
        done_k = -1;
        @(negedge clk);
        n_samples = ns; n_trees = nt; n_features = nf;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            if (pred_we && write_k < 0) write_k = k;
            if (done) begin
                done_k = k;
                break;
            end
            start = (k == inject);
            @(negedge clk);
        end
        start = 1'b0;
        if (done_k < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end
        @(negedge clk);
        @(negedge clk);
        chk({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_err"}, 64'(err), 64'(exp_err));
        chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        $display("task %s samples=%0d trees=%0d done_k=%0d err=%0b", name, ns, nt, done_k, err);
    endtask

    task automatic clear_mems();
        for (int i = 0; i < NT*TL; i++) tree_mem[i] = nd(1'b1, 0, 0, 0, 0);
        for (int i = 0; i < MS; i++) begin feat_mem[i] = '0; pred_mem[i] = 32'hdead_beef; end
    endtask

    task automatic setup_stump();
        clear_mems();
        tree_mem[0] = nd(1'b0, 1, 2, 0, 5);
        tree_mem[1] = nd(1'b1, 0, 0, 0, 10);
        tree_mem[2] = nd(1'b1, 0, 0, 0, -3);
        feat_mem[0] = 32'd4;
        feat_mem[1] = 32'd6;
    endtask

    task automatic setup_deep();
        clear_mems();
        tree_mem[0] = nd(1'b0, 1, 2, 2, -1);
        tree_mem[1] = nd(1'b1, 0, 0, 0, 100);
        tree_mem[2] = nd(1'b0, 3, 1, 1, 0);
        tree_mem[3] = nd(1'b1, 0, 0, 0, 7);
        tree_mem[4] = nd(1'b1, 0, 0, 0, -50);
        feat_mem[0] = 0;  feat_mem[1] = 0;  feat_mem[2] = -5;
        feat_mem[3] = 9;  feat_mem[4] = 3;  feat_mem[5] = 2;
        feat_mem[6] = 1;  feat_mem[7] = -2; feat_mem[8] = 0;
    endtask

    initial begin
        int wk, dk;
        clear_mems();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // 1: stump, two samples.
        setup_stump();
        run_task("stump", 2, 1, 1, 0, wk, dk);
        chk("stump_pred0", 64'(pred_mem[0]), 64'd10);
        chk("stump_pred1", 64'(pred_mem[1]), 64'(32'hffff_fffd));

        // 2: three single-leaf trees; write lands on the 7th cycle.
        clear_mems();
        tree_mem[0] = nd(1'b1, 0, 0, 0, 1);
        tree_mem[4] = nd(1'b1, 0, 0, 0, 2);
        tree_mem[8] = nd(1'b1, 0, 0, 0, 3);
        run_task("leaves", 1, 3, 1, 0, wk, dk);
        chk("leaves_pred0", 64'(pred_mem[0]), 64'd6);
        chk("leaves_write_cycle", 64'(wk), 64'd7);

        // 3: zero samples: done right after the start cycle, no writes.
        run_task("empty", 0, 1, 1, 0, wk, dk);
        chk("empty_done_cycle", 64'(dk), 64'd1);
        chk("empty_no_write", 64'(wk), 64'(-1));
        chk("empty_err", 64'(err), 64'd0);

        // 4: self loop hits the step budget.
        clear_mems();
        tree_mem[0] = nd(1'b0, 0, 0, 0, 5);
        run_task("loop", 1, 1, 1, 0, wk, dk);
        chk("loop_err", 64'(err), 64'd1);
        chk("loop_pred0", 64'(pred_mem[0]), 64'd0);

        // 5: out-of-range fidx; later trees still count.
        clear_mems();
        tree_mem[0] = nd(1'b0, 1, 2, 7, 0);
        tree_mem[4] = nd(1'b1, 0, 0, 0, 5);
        tree_mem[8] = nd(1'b1, 0, 0, 0, 7);
        run_task("badfidx", 1, 3, 4, 0, wk, dk);
        chk("badfidx_err", 64'(err), 64'd1);
        chk("badfidx_pred0", 64'(pred_mem[0]), 64'd12);

        // Deeper trees, three features, negative threshold, base stepping.
        setup_deep();
        run_task("deep", 3, 2, 3, 0, wk, dk);
        chk("deep_pred0", 64'(pred_mem[0]), 64'd50);
        chk("deep_pred1", 64'(pred_mem[1]), 64'd50);
        chk("deep_pred2", 64'(pred_mem[2]), 64'(32'hffff_ffd5));

        // 6: extra start mid-task is ignored.
        setup_deep();
        run_task("restart", 3, 2, 3, 3, wk, dk);
        chk("restart_pred2", 64'(pred_mem[2]), 64'(32'hffff_ffd5));

        // Reset mid-task aborts immediately.
        setup_deep();
        done_cnt = 0;
        @(negedge clk);
        n_samples = 3; n_trees = 2; n_features = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_zero("midreset");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midreset_no_done", 64'(done_cnt), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);

        // Fresh run after the abort.
        setup_stump();
        run_task("fresh", 2, 1, 1, 0, wk, dk);
        chk("fresh_pred0", 64'(pred_mem[0]), 64'd10);
        chk("fresh_pred1", 64'(pred_mem[1]), 64'(32'hffff_fffd));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
